// File: rtl/control_hs_if.sv
// ---------------------------------------------------------------------------
// control_hs_if
// Bundles the sequencer's handshake and datapath-control signals so the
// control_hs sequencer and the memory/datapath side share one port.
//
// Signals (direction as seen from the sequencer, modport master):
//   error_i            in   external fatal error, sampled each cycle
//   ir_i[31:0]         in   current instruction register contents
//   mem_ack_i          in   memory completed the current request this cycle
//   mem_req_o          out  memory request valid
//   mem_we_o           out  request is a write (store)
//   mem_rd_addr_sel_o  out  0 = PC, 1 = ALU_OUT
//   pc_we_o            out  PC write enable
//   ir_we_o            out  IR write enable
//   regfile_we_o       out  register file write enable
//   csr_we_o           out  CSR write enable
//   halted_o           out  core is in ERROR state
//   cause_o[1:0]       out  halt cause: 0 none, 1 external, 2 illegal, 3 timeout
//   state_o[2:0]       out  current state encoding, for debug
// The slave modport is the memory/datapath view of the same signals.
// ---------------------------------------------------------------------------
interface control_hs_if;
    logic        error_i;
    logic [31:0] ir_i;
    logic        mem_ack_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic        mem_rd_addr_sel_o;
    logic        pc_we_o;
    logic        ir_we_o;
    logic        regfile_we_o;
    logic        csr_we_o;
    logic        halted_o;
    logic [1:0]  cause_o;
    logic [2:0]  state_o;

    modport master (
        input  error_i, ir_i, mem_ack_i,
        output mem_req_o, mem_we_o, mem_rd_addr_sel_o, pc_we_o, ir_we_o,
               regfile_we_o, csr_we_o, halted_o, cause_o, state_o
    );

    modport slave (
        output error_i, ir_i, mem_ack_i,
        input  mem_req_o, mem_we_o, mem_rd_addr_sel_o, pc_we_o, ir_we_o,
               regfile_we_o, csr_we_o, halted_o, cause_o, state_o
    );
endinterface

// File: rtl/control_hs.sv
// ---------------------------------------------------------------------------
// control_hs
// Multi-cycle control sequencer for the tiny5 core. Instruction fetch and
// load/store accesses use a req/ack memory handshake of arbitrary latency.
// Adds illegal-opcode detection, a memory wait watchdog and a sticky halt
// with a cause code. Only datapath enables are driven here; ALU/mux/compare
// selects stay in the combinational decoder.
//
// Parameters:
//   MEM_TIMEOUT  max wait cycles for one memory request (0 disables watchdog)
//   TIMEOUT_W    width of the wait counter
//   COUNTER_W    width of the performance counters (optional feature only)
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset
//   bus          control_hs_if.master (handshake, instruction, enables, status)
//   cycle_o      cycles spent outside RESET/ERROR   (TINY5_PERF_COUNTERS_EN)
//   instret_o    cycles with pc_we_o asserted       (TINY5_PERF_COUNTERS_EN)
//
// Optional feature macro: TINY5_PERF_COUNTERS_EN adds the two performance
// counters; without it neither the ports nor the counter logic exist.
// ---------------------------------------------------------------------------
module control_hs #(
    parameter int MEM_TIMEOUT = 256,
    parameter int TIMEOUT_W   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1)
`ifdef TINY5_PERF_COUNTERS_EN
    ,
    parameter int COUNTER_W   = 64
`endif
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    control_hs_if.master         bus
`ifdef TINY5_PERF_COUNTERS_EN
    ,
    output logic [COUNTER_W-1:0] cycle_o,
    output logic [COUNTER_W-1:0] instret_o
`endif
);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

    localparam logic [1:0] CAUSE_EXT     = 2'd1;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    state_t               r_state;
    state_t               w_stateNext;
    logic [1:0]           r_cause;
    logic [1:0]           w_causeNext;
    logic [TIMEOUT_W-1:0] r_waitCnt;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_isStore;
    logic       w_timeout;
    logic       w_unusedIr;

    logic w_memReq;
    logic w_memWe;
    logic w_memSel;
    logic w_pcWe;
    logic w_irWe;
    logic w_rfWe;
    logic w_csrWe;

    assign w_opcode   = bus.ir_i[6:0];
    assign w_funct3   = bus.ir_i[14:12];
    assign w_isStore  = (w_opcode == OPC_STORE);
    assign w_unusedIr = ^{bus.ir_i[31:15], bus.ir_i[11:7]};

    // Watchdog fires when the current request has waited MEM_TIMEOUT cycles
    // and still sees no ack this cycle.
    assign w_timeout = (MEM_TIMEOUT != 0) &&
                       (r_waitCnt == TIMEOUT_W'(MEM_TIMEOUT));

    // State, cause and wait counter registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= ST_RESET;
            r_cause <= 2'd0;
        end else begin
            r_state <= w_stateNext;
            r_cause <= w_causeNext;
        end
    end

    // Wait counter restarts on every state change so each FETCH/MEM request
    // gets its own budget; it saturates instead of wrapping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_waitCnt <= '0;
        end else if (w_stateNext != r_state) begin
            r_waitCnt <= '0;
        end else if ((r_state == ST_FETCH || r_state == ST_MEM) &&
                     !bus.mem_ack_i && (r_waitCnt != '1)) begin
            r_waitCnt <= r_waitCnt + TIMEOUT_W'(1);
        end
    end

    // Next-state and output decode. The external error override comes last
    // so it wins over ack, illegal opcode and timeout, and kills the enables.
    always_comb begin
        w_stateNext = r_state;
        w_causeNext = r_cause;
        w_memReq    = 1'b0;
        w_memWe     = 1'b0;
        w_memSel    = 1'b0;
        w_pcWe      = 1'b0;
        w_irWe      = 1'b0;
        w_rfWe      = 1'b0;
        w_csrWe     = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_stateNext = ST_FETCH;
            end
            ST_FETCH: begin
                w_memReq = 1'b1;
                if (bus.mem_ack_i) begin
                    w_irWe      = 1'b1;
                    w_stateNext = ST_EXEC;
                end else if (w_timeout) begin
                    w_stateNext = ST_ERROR;
                    w_causeNext = CAUSE_TIMEOUT;
                end
            end
            ST_EXEC: begin
                case (w_opcode)
                    OPC_LOAD, OPC_STORE: begin
                        w_stateNext = ST_MEM;
                    end
                    OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
                        w_pcWe      = 1'b1;
                        w_rfWe      = 1'b1;
                        w_stateNext = ST_FETCH;
                    end
                    OPC_SYSTEM: begin
                        w_pcWe      = 1'b1;
                        w_rfWe      = 1'b1;
                        w_csrWe     = (w_funct3 != 3'd0);
                        w_stateNext = ST_FETCH;
                    end
                    OPC_BRANCH, OPC_MISC_MEM: begin
                        w_pcWe      = 1'b1;
                        w_stateNext = ST_FETCH;
                    end
                    default: begin
                        w_stateNext = ST_ERROR;
                        w_causeNext = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                w_memReq = 1'b1;
                w_memSel = 1'b1;
                w_memWe  = w_isStore;
                if (bus.mem_ack_i) begin
                    w_pcWe      = 1'b1;
                    w_rfWe      = !w_isStore;
                    w_stateNext = ST_FETCH;
                end else if (w_timeout) begin
                    w_stateNext = ST_ERROR;
                    w_causeNext = CAUSE_TIMEOUT;
                end
            end
            ST_ERROR: begin
                w_stateNext = ST_ERROR;
            end
            default: begin
                w_stateNext = ST_RESET;
            end
        endcase

        if (bus.error_i && r_state != ST_RESET && r_state != ST_ERROR) begin
            w_stateNext = ST_ERROR;
            w_causeNext = CAUSE_EXT;
            w_pcWe      = 1'b0;
            w_irWe      = 1'b0;
            w_rfWe      = 1'b0;
            w_csrWe     = 1'b0;
        end
    end

    assign bus.mem_req_o         = w_memReq;
    assign bus.mem_we_o          = w_memWe;
    assign bus.mem_rd_addr_sel_o = w_memSel;
    assign bus.pc_we_o           = w_pcWe;
    assign bus.ir_we_o           = w_irWe;
    assign bus.regfile_we_o      = w_rfWe;
    assign bus.csr_we_o          = w_csrWe;
    assign bus.halted_o          = (r_state == ST_ERROR);
    assign bus.cause_o           = r_cause;
    assign bus.state_o           = r_state;

`ifdef TINY5_PERF_COUNTERS_EN
    logic [COUNTER_W-1:0] r_cycle;
    logic [COUNTER_W-1:0] r_instret;

    // Free-running counters; both wrap naturally at 2^COUNTER_W.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            if (r_state == ST_FETCH || r_state == ST_EXEC || r_state == ST_MEM) begin
                r_cycle <= r_cycle + COUNTER_W'(1);
            end
            if (w_pcWe) begin
                r_instret <= r_instret + COUNTER_W'(1);
            end
        end
    end

    assign cycle_o   = r_cycle;
    assign instret_o = r_instret;
`endif

endmodule

// File: tb/tb_control_hs.sv
// ---------------------------------------------------------------------------
// tb_control_hs
// Self-checking bench for control_hs. The main DUT is driven one cycle at a
// time; every driven cycle pushes the outputs that cycle must show, worked
// out from instruction-level rules (instruction class, wait counts, injected
// errors). A single compare process checks them on the falling edge. Two
// extra DUTs (MEM_TIMEOUT = 4 and 0) exercise the watchdog. With
// TINY5_PERF_COUNTERS_EN defined the counters are checked as well.
// ---------------------------------------------------------------------------
module tb_control_hs;

    localparam logic [2:0] ST_RESET = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic [31:0] I_ADDI  = 32'h00100093;
    localparam logic [31:0] I_LW    = 32'h0000A103;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_ILL   = 32'h0000007F;
    localparam logic [31:0] I_LUI   = 32'h000010B7;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_FENCE = 32'h0000000F;
    localparam logic [31:0] I_CSRRW = 32'h30529073;
    localparam logic [31:0] I_ECALL = 32'h00000073;
    localparam logic [31:0] I_JAL   = 32'h0080006F;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_AUIPC = 32'h00000117;
    localparam logic [31:0] I_ADD   = 32'h002081B3;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       sel;
        logic       pcWe;
        logic       irWe;
        logic       rfWe;
        logic       csrWe;
        logic       halted;
        logic [1:0] cause;
    } exp_t;

    typedef enum {CLS_MEM, CLS_WB, CLS_PC, CLS_ILL} cls_t;

    logic clk = 1'b0;
    logic rst;
    logic rstT;

    always #5 clk = ~clk;

    control_hs_if busMain();
    control_hs_if busT4();
    control_hs_if busT0();

`ifdef TINY5_PERF_COUNTERS_EN
    logic [63:0] cycleMain, instretMain, cycleT4, instretT4, cycleT0, instretT0;
`endif

    control_hs #(.MEM_TIMEOUT(256)) dutMain (
        .clk_i(clk), .reset_i(rst), .bus(busMain)
`ifdef TINY5_PERF_COUNTERS_EN
        , .cycle_o(cycleMain), .instret_o(instretMain)
`endif
    );

    control_hs #(.MEM_TIMEOUT(4)) dutT4 (
        .clk_i(clk), .reset_i(rstT), .bus(busT4)
`ifdef TINY5_PERF_COUNTERS_EN
        , .cycle_o(cycleT4), .instret_o(instretT4)
`endif
    );

    control_hs #(.MEM_TIMEOUT(0)) dutT0 (
        .clk_i(clk), .reset_i(rstT), .bus(busT0)
`ifdef TINY5_PERF_COUNTERS_EN
        , .cycle_o(cycleT0), .instret_o(instretT0)
`endif
    );

    int    compared   = 0;
    int    mismatched = 0;
    int    cycleNo    = 0;
    exp_t  expQ[$];
    string labelQ[$];
    exp_t  curExp;
    exp_t  curAct;
    string curLabel;
    logic [1:0] mCause = 2'd0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, required);
        end
    endtask

    // Single compare process: one expected trace entry per driven cycle.
    always @(negedge clk) begin
        cycleNo++;
        if (expQ.size() > 0) begin
            curExp   = expQ.pop_front();
            curLabel = labelQ.pop_front();
            curAct   = {busMain.state_o, busMain.mem_req_o, busMain.mem_we_o,
                        busMain.mem_rd_addr_sel_o, busMain.pc_we_o, busMain.ir_we_o,
                        busMain.regfile_we_o, busMain.csr_we_o, busMain.halted_o,
                        busMain.cause_o};
            checkOutput($sformatf("%s@%0d", curLabel, cycleNo), 64'(curAct), 64'(curExp));
        end
    end

    function automatic exp_t mk(input logic [2:0] st, input logic req, input logic we,
                                input logic sel, input logic pcWe, input logic irWe,
                                input logic rfWe, input logic csrWe);
        exp_t e;
        e.st     = st;
        e.req    = req;
        e.we     = we;
        e.sel    = sel;
        e.pcWe   = pcWe;
        e.irWe   = irWe;
        e.rfWe   = rfWe;
        e.csrWe  = csrWe;
        e.halted = (st == ST_ERROR);
        e.cause  = mCause;
        return e;
    endfunction

    // Instruction classes as the ISA groups them.
    function automatic cls_t classify(input logic [31:0] ir);
        case (ir[6:0])
            7'b0000011, 7'b0100011: return CLS_MEM;
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b0010011, 7'b0110011, 7'b1110011: return CLS_WB;
            7'b1100011, 7'b0001111: return CLS_PC;
            default: return CLS_ILL;
        endcase
    endfunction

    task automatic applyStimulus(input logic r, input logic err, input logic [31:0] ir,
                                 input logic ack, input exp_t e, input string label);
        @(posedge clk);
        #1;
        rst               = r;
        busMain.error_i   = err;
        busMain.ir_i      = ir;
        busMain.mem_ack_i = ack;
        expQ.push_back(e);
        labelQ.push_back(label);
    endtask

    task automatic doReset(input logic errInReset);
        mCause = 2'd0;
        applyStimulus(1'b1, 1'b0, I_ADDI, 1'b0, mk(ST_RESET, 0, 0, 0, 0, 0, 0, 0), "reset held");
        applyStimulus(1'b0, errInReset, I_ADDI, 1'b1, mk(ST_RESET, 0, 0, 0, 0, 0, 0, 0), "reset release");
    endtask

    task automatic fetchPhase(input logic [31:0] ir, input int waits);
        for (int i = 0; i < waits; i++)
            applyStimulus(1'b0, 1'b0, ir, 1'b0, mk(ST_FETCH, 1, 0, 0, 0, 0, 0, 0), "fetch wait");
        applyStimulus(1'b0, 1'b0, ir, 1'b1, mk(ST_FETCH, 1, 0, 0, 0, 1, 0, 0), "fetch ack");
    endtask

    // Ack is driven high during EXEC to show it is ignored there.
    task automatic execPhase(input logic [31:0] ir);
        cls_t c;
        logic csr;
        exp_t e;
        c   = classify(ir);
        csr = (ir[6:0] == 7'b1110011) && (ir[14:12] != 3'd0);
        case (c)
            CLS_WB:  e = mk(ST_EXEC, 0, 0, 0, 1, 0, 1, csr);
            CLS_PC:  e = mk(ST_EXEC, 0, 0, 0, 1, 0, 0, 0);
            default: e = mk(ST_EXEC, 0, 0, 0, 0, 0, 0, 0);
        endcase
        applyStimulus(1'b0, 1'b0, ir, 1'b1, e, "exec");
        if (c == CLS_ILL) mCause = 2'd2;
    endtask

    task automatic memPhase(input logic [31:0] ir, input int waits, input logic errAtAck);
        logic st;
        st = (ir[6:0] == 7'b0100011);
        for (int i = 0; i < waits; i++)
            applyStimulus(1'b0, 1'b0, ir, 1'b0, mk(ST_MEM, 1, st, 1, 0, 0, 0, 0), "mem wait");
        if (errAtAck) begin
            applyStimulus(1'b0, 1'b1, ir, 1'b1, mk(ST_MEM, 1, st, 1, 0, 0, 0, 0), "mem ack+error");
            mCause = 2'd1;
        end else begin
            applyStimulus(1'b0, 1'b0, ir, 1'b1, mk(ST_MEM, 1, st, 1, 1, 0, !st, 0), "mem ack");
        end
    endtask

    task automatic runInstr(input logic [31:0] ir, input int fWaits, input int mWaits);
        fetchPhase(ir, fWaits);
        execPhase(ir);
        if (classify(ir) == CLS_MEM) memPhase(ir, mWaits, 1'b0);
    endtask

    // Error/ack activity in ERROR must neither move the state nor the cause.
    task automatic errorCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, (i % 3) == 0, I_ADDI, (i % 2) == 0,
                          mk(ST_ERROR, 0, 0, 0, 0, 0, 0, 0), "halted");
    endtask

    initial begin
        rst               = 1'b1;
        rstT              = 1'b1;
        busMain.error_i   = 1'b0;
        busMain.ir_i      = I_ADDI;
        busMain.mem_ack_i = 1'b0;
        busT4.error_i     = 1'b0;
        busT4.ir_i        = I_ADDI;
        busT4.mem_ack_i   = 1'b0;
        busT0.error_i     = 1'b0;
        busT0.ir_i        = I_ADDI;
        busT0.mem_ack_i   = 1'b0;

        // Literal pins for the classifier.
        checkOutput("cls addi", 64'(classify(I_ADDI)), 64'(CLS_WB));
        checkOutput("cls lw", 64'(classify(I_LW)), 64'(CLS_MEM));
        checkOutput("cls sw", 64'(classify(I_SW)), 64'(CLS_MEM));
        checkOutput("cls beq", 64'(classify(I_BEQ)), 64'(CLS_PC));
        checkOutput("cls illegal", 64'(classify(I_ILL)), 64'(CLS_ILL));

        // Watchdog DUTs: ack never given in FETCH.
        @(posedge clk);
        #1;
        rstT = 1'b0;
        checkOutput("t4 reset state", 64'(busT4.state_o), 64'(ST_RESET));
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) checkOutput("t4 fetch req", 64'(busT4.mem_req_o), 64'd1);
            if (k == 5) checkOutput("t4 still fetch", 64'(busT4.state_o), 64'(ST_FETCH));
            if (k == 6) begin
                checkOutput("t4 timeout state", 64'(busT4.state_o), 64'(ST_ERROR));
                checkOutput("t4 timeout cause", 64'(busT4.cause_o), 64'd3);
                checkOutput("t4 halted", 64'(busT4.halted_o), 64'd1);
            end
        end
        for (int k = 7; k <= 1005; k++) @(posedge clk);
        #1;
        checkOutput("t0 fetch after 1000", 64'(busT0.state_o), 64'(ST_FETCH));
        checkOutput("t0 cause none", 64'(busT0.cause_o), 64'd0);
        checkOutput("t0 req held", 64'(busT0.mem_req_o), 64'd1);
        checkOutput("t4 sticky cause", 64'(busT4.cause_o), 64'd3);
        #1;
        rstT = 1'b1;
        #1;
        checkOutput("t0 req drops on async reset", 64'(busT0.mem_req_o), 64'd0);
        checkOutput("t4 cause cleared by reset", 64'(busT4.cause_o), 64'd0);

        // Main DUT: error during RESET is ignored; ADDI with 1-cycle fetch.
        doReset(1'b1);
        fetchPhase(I_ADDI, 0);
        #1;
        checkOutput("addi ir_we cycle2", 64'(busMain.ir_we_o), 64'd1);
        execPhase(I_ADDI);
        #1;
        checkOutput("addi pc_we cycle3", 64'(busMain.pc_we_o), 64'd1);
        checkOutput("addi rf_we cycle3", 64'(busMain.regfile_we_o), 64'd1);

        runInstr(I_LW, 3, 2);
        runInstr(I_SW, 0, 0);
        runInstr(I_LUI, 1, 0);
        runInstr(I_BEQ, 0, 0);
        runInstr(I_FENCE, 2, 0);
        runInstr(I_CSRRW, 0, 0);
        runInstr(I_ECALL, 0, 0);
        runInstr(I_JAL, 0, 0);
        runInstr(I_JALR, 1, 0);
        runInstr(I_AUIPC, 0, 0);
        runInstr(I_ADD, 0, 0);

        // External error coinciding with MEM ack.
        fetchPhase(I_LW, 0);
        execPhase(I_LW);
        memPhase(I_LW, 1, 1'b1);
        errorCycles(5);

        // Illegal opcode, sticky for 100 cycles.
        doReset(1'b0);
        fetchPhase(I_ILL, 1);
        execPhase(I_ILL);
        errorCycles(100);
        #2;
        checkOutput("illegal halted", 64'(busMain.halted_o), 64'd1);
        checkOutput("illegal cause", 64'(busMain.cause_o), 64'd2);
        checkOutput("illegal state", 64'(busMain.state_o), 64'(ST_ERROR));

        // External error together with a FETCH ack: ir_we suppressed.
        doReset(1'b0);
        applyStimulus(1'b0, 1'b0, I_ADDI, 1'b0, mk(ST_FETCH, 1, 0, 0, 0, 0, 0, 0), "fetch wait");
        applyStimulus(1'b0, 1'b1, I_ADDI, 1'b1, mk(ST_FETCH, 1, 0, 0, 0, 0, 0, 0), "fetch ack+error");
        mCause = 2'd1;
        errorCycles(3);

        // External error during EXEC of a valid instruction.
        doReset(1'b0);
        fetchPhase(I_ADDI, 0);
        applyStimulus(1'b0, 1'b1, I_ADDI, 1'b0, mk(ST_EXEC, 0, 0, 0, 0, 0, 0, 0), "exec+error");
        mCause = 2'd1;
        errorCycles(2);

`ifdef TINY5_PERF_COUNTERS_EN
        doReset(1'b0);
        for (int i = 0; i < 5; i++) runInstr(I_ADDI, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("instret after 5 addi", instretMain, 64'd5);
        checkOutput("cycle after 5 addi", cycleMain, 64'd10);
`endif

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("trace queue drained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
